udp_src_scheduler: RTL and testbench

Frame-level scheduler that drives `sel_cam` of `udp_source_mux` and decides whether the camera or the SD/TF source owns the UDP transmit path. It grants one source per frame, switches only on frame boundaries and inserts a fixed inter-frame gap before the next grant. It arbitrates round-robin when both sources are waiting, and holds off all traffic until SDRAM init completes. It sits between the two source front-ends and `udp_source_mux`.

---
 rtl/udp_sched_pkg.sv | 22 ++
 rtl/udp_sched_wdog.sv | 39 +++
 rtl/udp_src_scheduler.sv | 148 ++++++++++++++
 tb/tb_udp_src_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_sched_pkg.sv
// Shared encodings for the UDP source scheduler: FSM states, last-source tag
// and a small helper that says which states count as busy.
package udp_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_CAM  = 3'd2,
    ST_SD   = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  typedef enum logic {
    SRC_SD  = 1'b0,
    SRC_CAM = 1'b1
  } src_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_CAM) || (s == ST_SD) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/udp_sched_wdog.sv
// Frame watchdog: cleared when a grant is issued, counts while a source owns
// the path, and flags expiry on the WDOG_CYCLES-th granted cycle.
import udp_sched_pkg::*;

module udp_sched_wdog #(
  parameter int WDOG_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(WDOG_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds (granted cycles - 1), so this fires during cycle WDOG_CYCLES.
  assign expire = run && (cnt_q == LIMIT);

endmodule

// File: rtl/udp_src_scheduler.sv
// Frame-level owner of the UDP transmit path (camera vs SD/TF) with round-robin,
// fixed inter-frame gap and SDRAM-init gating. UDP_SCHED_WDOG_EN adds a frame watchdog.
import udp_sched_pkg::*;

module udp_src_scheduler #(
  parameter int GAP_CYCLES  = 16,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Sdr_init_done,
  input  logic        cam_req,
  input  logic        sd_req,
  input  logic        cam_data_done,
  input  logic        sd_data_done,
  output logic        sel_cam,
  output logic        cam_grant,
  output logic        sd_grant,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        wdog_abort,
  output logic [2:0]  dbg_state
);

  // Handshake: a source raises *_req and holds it until *_grant is seen high;
  // the grant then stays high for the whole frame and drops on the edge that
  // samples the one-cycle *_data_done (or on watchdog expiry).

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  src_e        last_src_q, last_src_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sel_cam_q, sel_cam_d;
  logic        cam_grant_q, cam_grant_d;
  logic        sd_grant_q, sd_grant_d;
  logic        busy_q, busy_d;
  logic        wdog_abort_q, wdog_abort_d;
  logic        expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      last_src_q   <= SRC_SD;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      sel_cam_q    <= 1'b0;
      cam_grant_q  <= 1'b0;
      sd_grant_q   <= 1'b0;
      busy_q       <= 1'b0;
      wdog_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_src_q   <= last_src_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      sel_cam_q    <= sel_cam_d;
      cam_grant_q  <= cam_grant_d;
      sd_grant_q   <= sd_grant_d;
      busy_q       <= busy_d;
      wdog_abort_q <= wdog_abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_src_d   = last_src_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    wdog_abort_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (Sdr_init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!Sdr_init_done) begin
          state_d = ST_INIT;
        end else if (cam_req && (!sd_req || last_src_q == SRC_SD)) begin
          state_d    = ST_CAM;
          last_src_d = SRC_CAM;
        end else if (sd_req) begin
          state_d    = ST_SD;
          last_src_d = SRC_SD;
        end
      end
      ST_CAM, ST_SD: begin
        // A done on the expiry cycle is a normal completion.
        if ((state_q == ST_CAM) ? cam_data_done : sd_data_done) begin
          state_d     = ST_GAP;
          gap_cnt_d   = GAP_LOAD;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (expire) begin
          state_d      = ST_GAP;
          gap_cnt_d    = GAP_LOAD;
          wdog_abort_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state flop.
  always_comb begin
    sel_cam_d = sel_cam_q;
    if (state_q == ST_IDLE && state_d == ST_CAM) sel_cam_d = 1'b1;
    if (state_q == ST_IDLE && state_d == ST_SD)  sel_cam_d = 1'b0;
    cam_grant_d = (state_d == ST_CAM);
    sd_grant_d  = (state_d == ST_SD);
    busy_d      = is_busy(state_d);
  end

`ifdef UDP_SCHED_WDOG_EN
  logic wdog_clear, wdog_run;
  assign wdog_run   = (state_q == ST_CAM) || (state_q == ST_SD);
  assign wdog_clear = (state_q == ST_IDLE) && ((state_d == ST_CAM) || (state_d == ST_SD));

  udp_sched_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clear (wdog_clear),
    .run   (wdog_run),
    .expire(expire)
  );
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign expire          = 1'b0;
`endif

  assign sel_cam    = sel_cam_q;
  assign cam_grant  = cam_grant_q;
  assign sd_grant   = sd_grant_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign wdog_abort = wdog_abort_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_udp_src_scheduler.sv
// Directed bench for udp_src_scheduler: frame-level reference model, per-cycle
// compare, grant-order scoreboard and hand-computed spot values.
module tb_udp_src_scheduler;

  localparam int GAP  = 16;
  localparam int WDOG = 200;
`ifdef UDP_SCHED_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        Sdr_init_done;
  logic        cam_req;
  logic        sd_req;
  logic        cam_data_done;
  logic        sd_data_done;
  logic        sel_cam;
  logic        cam_grant;
  logic        sd_grant;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        wdog_abort;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected grant order: 1 = camera, 0 = SD.
  logic [0:0] exp_q[$];

  udp_src_scheduler #(
    .GAP_CYCLES (GAP),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Sdr_init_done(Sdr_init_done),
    .cam_req      (cam_req),
    .sd_req       (sd_req),
    .cam_data_done(cam_data_done),
    .sd_data_done (sd_data_done),
    .sel_cam      (sel_cam),
    .cam_grant    (cam_grant),
    .sd_grant     (sd_grant),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .wdog_abort   (wdog_abort),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Frame-level view: who owns the path, how many gap cycles remain,
  // whether SDRAM init has been seen, and who was served last.
  bit          m_valid = 1'b0;
  bit          m_ready = 1'b0;
  bit          m_last_cam = 1'b0;
  bit          m_sel = 1'b0;
  bit          m_abort = 1'b0;
  int          m_owner = 0;   // 0 none, 1 camera, 2 SD
  int          m_gap_left = 0;
  int          m_age = 0;
  logic [15:0] m_frames = '0;
  bit          preload_req = 1'b0;

  always @(posedge clk) begin
    m_abort = 1'b0;
    if (reset) begin
      m_valid    = 1'b1;
      m_ready    = 1'b0;
      m_last_cam = 1'b0;
      m_sel      = 1'b0;
      m_owner    = 0;
      m_gap_left = 0;
      m_age      = 0;
      m_frames   = '0;
    end else if (m_owner != 0) begin
      m_age++;
      if ((m_owner == 1 && cam_data_done) || (m_owner == 2 && sd_data_done)) begin
        m_owner    = 0;
        m_gap_left = GAP;
        m_frames   = m_frames + 16'd1;
      end else if (WDOG_ON && m_age == WDOG) begin
        m_owner    = 0;
        m_gap_left = GAP;
        m_abort    = 1'b1;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (!m_ready) begin
      m_ready = Sdr_init_done;
    end else if (!Sdr_init_done) begin
      m_ready = 1'b0;
    end else if (cam_req && !(sd_req && m_last_cam)) begin
      m_owner = 1; m_last_cam = 1'b1; m_sel = 1'b1; m_age = 0;
    end else if (sd_req) begin
      m_owner = 2; m_last_cam = 1'b0; m_sel = 1'b0; m_age = 0;
    end
    if (preload_req) begin
      m_frames = 16'hFFFF;
      #1;
      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
    end
  end

  function automatic logic [2:0] model_state();
    if (m_owner == 1) return 3'd2;
    if (m_owner == 2) return 3'd3;
    if (m_gap_left > 0) return 3'd4;
    if (m_ready) return 3'd1;
    return 3'd0;
  endfunction

  // ---------------- compare + scoreboard ----------------
  bit prev_grant = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("sel_cam", {31'd0, sel_cam}, {31'd0, m_sel});
      check("cam_grant", {31'd0, cam_grant}, {31'd0, m_owner == 1});
      check("sd_grant", {31'd0, sd_grant}, {31'd0, m_owner == 2});
      check("busy", {31'd0, busy}, {31'd0, (m_owner != 0) || (m_gap_left > 0)});
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frames});
      check("wdog_abort", {31'd0, wdog_abort}, {31'd0, m_abort});
      check("state", {29'd0, dbg_state}, {29'd0, model_state()});
      if ((cam_grant || sd_grant) && !prev_grant) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL grant_order: unexpected grant sel_cam=%0b, expected no grant", sel_cam);
        end else begin
          check("grant_order", {31'd0, sel_cam}, {31'd0, exp_q.pop_front()});
        end
      end
      prev_grant = cam_grant || sd_grant;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_done(input bit cam);
    if (cam) cam_data_done = 1'b1; else sd_data_done = 1'b1;
    tick(1);
    cam_data_done = 1'b0;
    sd_data_done  = 1'b0;
  endtask

  task automatic wait_grant(input bit cam);
    int n;
    n = 0;
    while (n < 300 && !(cam ? cam_grant : sd_grant)) begin
      tick(1);
      n++;
    end
    check(cam ? "wait_cam_grant" : "wait_sd_grant", {31'd0, cam ? cam_grant : sd_grant}, 32'd1);
  endtask

  task automatic measure_gap(input int want);
    int low;
    low = 0;
    while (low < 100 && !(cam_grant || sd_grant)) begin
      low++;
      tick(1);
    end
    check("gap_low_cycles", low, want);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    Sdr_init_done = 1'b0;
    cam_req = 1'b0;
    sd_req = 1'b0;
    cam_data_done = 1'b0;
    sd_data_done = 1'b0;
    tick(3);
    check("rst_cam_grant", {31'd0, cam_grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // Init gating: no grant until SDRAM ready, then INIT->IDLE->CAM.
    cam_req = 1'b1;
    exp_q.push_back(1'b1);
    tick(50);
    check("gate_no_grant", {31'd0, cam_grant}, 32'd0);
    Sdr_init_done = 1'b1;
    tick(1);
    check("gate_edge1_grant", {31'd0, cam_grant}, 32'd0);
    tick(1);
    check("gate_edge2_grant", {31'd0, cam_grant}, 32'd1);
    check("gate_edge2_sel", {31'd0, sel_cam}, 32'd1);
    cam_req = 1'b0;
    tick(30);
    pulse_done(1'b1);
    check("gate_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // Round-robin with both requests held: CAM, SD, CAM, SD.
    do_reset();
    cam_req = 1'b1;
    sd_req  = 1'b1;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    for (int f = 0; f < 4; f++) begin
      wait_grant(f % 2 == 0);
      tick(99);
      pulse_done(f % 2 == 0);
      if (f == 3) begin
        cam_req = 1'b0;
        sd_req  = 1'b0;
      end else begin
        measure_gap(GAP + 1);
      end
    end
    check("rr_frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // Cross done: SD done during a camera frame is ignored.
    do_reset();
    cam_req = 1'b1;
    exp_q.push_back(1'b1);
    wait_grant(1'b1);
    cam_req = 1'b0;
    tick(20);
    pulse_done(1'b0);
    check("cross_grant_held", {31'd0, cam_grant}, 32'd1);
    check("cross_frame_cnt0", {16'd0, frame_cnt}, 32'd0);
    tick(10);
    pulse_done(1'b1);
    check("cross_grant_drop", {31'd0, cam_grant}, 32'd0);
    check("cross_frame_cnt1", {16'd0, frame_cnt}, 32'd1);
    check("cross_busy_gap", {31'd0, busy}, 32'd1);

    // Init drop mid-frame: frame finishes, GAP, IDLE, INIT; then no grants.
    sd_req = 1'b1;
    exp_q.push_back(1'b0);
    wait_grant(1'b0);
    tick(9);
    Sdr_init_done = 1'b0;
    tick(20);
    check("drop_sd_held", {31'd0, sd_grant}, 32'd1);
    pulse_done(1'b0);
    check("drop_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    tick(17);
    check("drop_state_init", {29'd0, dbg_state}, 32'd0);
    check("drop_busy", {31'd0, busy}, 32'd0);
    cam_req = 1'b1;
    tick(30);
    check("drop_no_cam", {31'd0, cam_grant}, 32'd0);
    check("drop_no_sd", {31'd0, sd_grant}, 32'd0);

    // Reset mid-frame, then last-source must be back to SD (camera wins).
    sd_req = 1'b0;
    Sdr_init_done = 1'b1;
    exp_q.push_back(1'b1);
    wait_grant(1'b1);
    tick(10);
    reset = 1'b1;
    tick(1);
    check("mrst_sel", {31'd0, sel_cam}, 32'd0);
    check("mrst_cam_grant", {31'd0, cam_grant}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("mrst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    cam_req = 1'b1;
    sd_req  = 1'b1;
    exp_q.push_back(1'b1);
    wait_grant(1'b1);
    cam_req = 1'b0;
    sd_req  = 1'b0;
    tick(5);
    pulse_done(1'b1);
    check("mrst_after_cnt", {16'd0, frame_cnt}, 32'd1);

    if (WDOG_ON) begin
      // Watchdog: silent camera frame aborted on cycle 200; then done on cycle 200 wins.
      do_reset();
      cam_req = 1'b1;
      exp_q.push_back(1'b1);
      wait_grant(1'b1);
      cam_req = 1'b0;
      tick(199);
      check("wd_pre_abort", {31'd0, wdog_abort}, 32'd0);
      check("wd_pre_grant", {31'd0, cam_grant}, 32'd1);
      tick(1);
      check("wd_abort", {31'd0, wdog_abort}, 32'd1);
      check("wd_grant_drop", {31'd0, cam_grant}, 32'd0);
      check("wd_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      tick(1);
      check("wd_abort_pulse", {31'd0, wdog_abort}, 32'd0);
      cam_req = 1'b1;
      exp_q.push_back(1'b1);
      wait_grant(1'b1);
      cam_req = 1'b0;
      tick(199);
      cam_data_done = 1'b1;
      tick(1);
      cam_data_done = 1'b0;
      check("wd_tie_abort", {31'd0, wdog_abort}, 32'd0);
      check("wd_tie_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    end

    // Wrap: preload 16'hFFFF completed frames, one more frame gives 0.
    do_reset();
    preload_req = 1'b1;
    tick(1);
    #2;
    preload_req = 1'b0;
    tick(1);
    check("wrap_preload", {16'd0, frame_cnt}, 32'hFFFF);
    cam_req = 1'b1;
    exp_q.push_back(1'b1);
    wait_grant(1'b1);
    cam_req = 1'b0;
    tick(5);
    pulse_done(1'b1);
    check("wrap_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    tick(30);
    check("grants_outstanding", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
